// File: rtl/accumulate_if.sv
// Handshake bundle for the frame accumulator: producer-side input beats and
// consumer-side result beats, plus the busy status.
interface accumulate_if #(
  parameter int unsigned W = 16,
  parameter int unsigned G = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W+G-1:0]   out_data;
  logic             out_ovf;
  logic             busy;

  // Environment side: drives products in and takes results out.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ovf,
    input  busy
  );

  // Accumulator side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ovf,
    output busy
  );
endinterface

// File: rtl/accumulate.sv
// Frame accumulator: sums N signed products per frame with saturation into
// W+G bits and presents each frame sum through a valid/ready result port.
module accumulate #(
  parameter int unsigned W = 16,
  parameter int unsigned G = 4,
  parameter int unsigned N = 8
) (
  input logic         clk,
  input logic         rst_n,
  accumulate_if.slave bus
);

  localparam int unsigned OW = W + G;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] StAcc  = 1'b0;
  localparam logic [0:0] StHold = 1'b1;

  localparam logic [CW-1:0] CntLast = CW'(N - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [OW-1:0] SatMax  = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] SatMin  = {1'b1, {(OW-1){1'b0}}};

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [OW-1:0] res_q, res_d;
  logic          res_ovf_q, res_ovf_d;

  logic          out_valid;
  logic          in_ready;
  logic          accept;
  logic          xfer;
  logic          first;
  logic          last;

  logic [OW:0]   data_ext;
  logic [OW:0]   base_ext;
  logic [OW:0]   sum;
  logic          sat;
  logic [OW-1:0] sum_sat;
  logic          ovf_acc;

  // Handshake decode
  assign out_valid = (state_q == StHold);
  // A held result frees the input only when the consumer takes it this cycle.
  assign in_ready  = !out_valid || bus.out_ready;
  assign accept    = bus.in_valid && in_ready;
  assign xfer      = out_valid && bus.out_ready;
  assign first     = (cnt_q == '0);
  assign last      = (cnt_q == CntLast);

  // Datapath: one guard bit above the output width detects overflow.
  always_comb begin
    data_ext = {{(G + 1){bus.in_data[W-1]}}, bus.in_data};
    // First beat of a frame starts from zero rather than the stale sum.
    base_ext = first ? '0 : {acc_q[OW-1], acc_q};
    sum      = base_ext + data_ext;
    sat      = sum[OW] ^ sum[OW-1];
    if (sat) begin
      sum_sat = sum[OW] ? SatMin : SatMax;
    end else begin
      sum_sat = sum[OW-1:0];
    end
    ovf_acc = sat | (!first & ovf_q);
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    res_ovf_d = res_ovf_q;

    if (xfer) begin
      state_d = StAcc;
    end

    if (accept) begin
      if (last) begin
        // Frame-ending beat wins over the transfer so N=1 can stream.
        res_d     = sum_sat;
        res_ovf_d = ovf_acc;
        cnt_d     = '0;
        state_d   = StHold;
      end else begin
        acc_d = sum_sat;
        ovf_d = ovf_acc;
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  // State registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StAcc;
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  // Outputs
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = res_q;
  assign bus.out_ovf   = res_ovf_q;
  assign bus.busy      = (cnt_q != '0);

endmodule
